// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// CPU pushes bytes at offset 0, polls count/status, clears overflow at offset 2.
module uart_tx_io #(
    parameter int BAUD_DIV   = 2396,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        UARTCtrl,
    input  logic        ioWrite,
    input  logic        ioRead,
    input  logic [1:0]  uartAddr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic wr_acc;
    logic rd_acc;
    logic push_req;
    logic push;
    logic pop;
    logic ovf_clr;
    logic empty;
    logic full;
    logic busy;
    logic baud_end;
    logic [3:0] count4;
    logic unused_wd;

    assign wr_acc    = UARTCtrl & ioWrite;
    assign rd_acc    = UARTCtrl & ioRead;
    assign push_req  = wr_acc & (uartAddr == 2'b00);
    assign ovf_clr   = wr_acc & (uartAddr == 2'b10) & write_data[2];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign busy      = (state_q != IDLE) | ~empty;
    assign baud_end  = (baud_q == BW'(BAUD_DIV - 1));
    assign count4    = 4'(count_q);
    assign unused_wd = ^write_data[15:8];
    assign tx        = tx_q;

    // A pop frees a slot in the same cycle, so a push while full still lands.
    assign push = push_req & (~full | pop);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    // Line level follows the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = write_data[7:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        read_data = 16'h0000;
        if (rd_acc && !reset) begin
            unique case (uartAddr)
                2'b00:   read_data = {12'b0, count4};
                2'b10:   read_data = {13'b0, ovf_q, full, busy};
                default: read_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: directed stores/loads, expected bytes queued for a
// serial-line monitor that decodes each frame and checks it against the queue.
module tb_uart_tx_io;

    logic        clock;
    logic        reset;
    logic        UARTCtrl;
    logic        ioWrite;
    logic        ioRead;
    logic [1:0]  uartAddr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        tx;

    uart_tx_io #(
        .BAUD_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .UARTCtrl   (UARTCtrl),
        .ioWrite    (ioWrite),
        .ioRead     (ioRead),
        .uartAddr   (uartAddr),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         aborted  = 0;
    logic [7:0] expq[$];
    int         sq[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        UARTCtrl   = 1'b1;
        ioWrite    = 1'b1;
        uartAddr   = a;
        write_data = d;
        @(posedge clock);
        #1;
        UARTCtrl   = 1'b0;
        ioWrite    = 1'b0;
        write_data = 16'h0000;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e,
                      input string name);
        UARTCtrl = 1'b1;
        ioRead   = 1'b1;
        uartAddr = a;
        #1;
        chk(name, int'(read_data), int'(e));
        UARTCtrl = 1'b0;
        ioRead   = 1'b0;
    endtask

    task automatic chk_start(input int exp, input string name);
        if (sq.size() == 0) begin
            chk(name, -1, exp);
        end else begin
            chk(name, sq.pop_front(), exp);
        end
    endtask

    task automatic idle_lows(input int n, input string name);
        int lows = 0;
        repeat (n) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        @(posedge clock);
        #1;
        chk(name, lows, 0);
    endtask

    // Serial monitor: every line sample of a bit period must agree.
    task automatic rx_frame();
        logic [9:0] bits = '0;
        bit stable = 1'b1;
        bit ab = 1'b0;
        sq.push_back(cyc);
        for (int b = 0; b < 10 && !ab; b++) begin
            for (int s = 0; s < 4 && !ab; s++) begin
                if (b != 0 || s != 0) @(negedge clock);
                if (reset) begin
                    ab = 1'b1;
                end else if (s == 0) begin
                    bits[b] = tx;
                end else if (tx !== bits[b]) begin
                    stable = 1'b0;
                end
            end
        end
        if (ab) begin
            aborted++;
        end else begin
            chk("frame_shape", int'({stable, bits[0], bits[9]}), 3'b101);
            chk("frame_expected_avail", int'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                chk("frame_data", int'(bits[8:1]), int'(expq.pop_front()));
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && tx === 1'b0) rx_frame();
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] t4_bytes [6];
    logic [7:0] t5_bytes [6];
    int n;

    initial begin : stim
        t4_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        t5_bytes = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h3C};
        reset      = 1'b1;
        UARTCtrl   = 1'b0;
        ioWrite    = 1'b0;
        ioRead     = 1'b0;
        uartAddr   = 2'b00;
        write_data = 16'h0000;
        step(3);
        reset = 1'b0;

        // reset state and idle line
        chk("rst_tx", int'(tx), 1);
        rd(2'b10, 16'h0000, "rst_status");
        rd(2'b00, 16'h0000, "rst_count");
        ioRead   = 1'b1;
        uartAddr = 2'b10;
        #1;
        chk("rd_unselected", int'(read_data), 0);
        ioRead = 1'b0;
        idle_lows(10, "idle_tx_low");

        // single byte 0xA5
        wr(2'b00, 16'h00A5);
        n = cyc;
        expq.push_back(8'hA5);
        rd(2'b00, 16'h0001, "t2_count_after_push");
        step(1);
        chk("t2_tx_start", int'(tx), 0);
        rd(2'b10, 16'h0001, "t2_busy_start");
        rd(2'b00, 16'h0000, "t2_count_after_pop");
        step(19);
        rd(2'b10, 16'h0001, "t2_busy_mid");
        step(20);
        rd(2'b10, 16'h0001, "t2_busy_stop");
        step(1);
        rd(2'b10, 16'h0000, "t2_idle_status");
        chk_start(n + 1, "t2_start_cycle");

        // back-to-back 0x55, 0x0F
        wr(2'b00, 16'h0055);
        n = cyc;
        expq.push_back(8'h55);
        wr(2'b00, 16'h000F);
        expq.push_back(8'h0F);
        rd(2'b00, 16'h0001, "t3_count_pushpop");
        step(79);
        rd(2'b10, 16'h0001, "t3_busy_last");
        step(1);
        rd(2'b10, 16'h0000, "t3_idle");
        chk_start(n + 1, "t3_start1");
        chk_start(n + 41, "t3_start2");

        // overflow: six stores, first popped, four buffered, sixth dropped
        for (int i = 0; i < 6; i++) begin
            wr(2'b00, {8'h00, t4_bytes[i]});
            if (i == 0) n = cyc;
            if (i < 5) expq.push_back(t4_bytes[i]);
        end
        rd(2'b10, 16'h0007, "t4_status_ovf");
        rd(2'b00, 16'h0004, "t4_count_full");
        rd(2'b01, 16'h0000, "t4_addr01");
        wr(2'b10, 16'h0003);
        rd(2'b10, 16'h0007, "t4_ovf_kept");
        wr(2'b10, 16'h0004);
        rd(2'b10, 16'h0003, "t4_ovf_cleared");
        wr(2'b11, 16'hFFFF);
        rd(2'b00, 16'h0004, "t4_addr11_ignored");
        rd(2'b11, 16'h0000, "t4_addr11_read");
        step(193);
        rd(2'b10, 16'h0000, "t4_drained");
        for (int i = 0; i < 5; i++) chk_start(n + 1 + 40 * i, "t4_start");

        // push while full on the stop-end pop cycle
        for (int i = 0; i < 5; i++) begin
            wr(2'b00, {8'h00, t5_bytes[i]});
            if (i == 0) n = cyc;
            expq.push_back(t5_bytes[i]);
        end
        step(36);
        rd(2'b10, 16'h0003, "t5_full_before");
        wr(2'b00, {8'h00, t5_bytes[5]});
        expq.push_back(t5_bytes[5]);
        rd(2'b10, 16'h0003, "t5_status_after");
        rd(2'b00, 16'h0004, "t5_count_after");
        step(200);
        rd(2'b10, 16'h0000, "t5_drained");
        for (int i = 0; i < 6; i++) chk_start(n + 1 + 40 * i, "t5_start");

        // reset during data bit 3 of 0xF0, with 0x77 still queued
        wr(2'b00, 16'h00F0);
        n = cyc;
        expq.push_back(8'hF0);
        wr(2'b00, 16'h0077);
        expq.push_back(8'h77);
        step(16);
        chk("t6_tx_bit3", int'(tx), 0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_tx_after_reset", int'(tx), 1);
        rd(2'b00, 16'h0000, "t6_count");
        rd(2'b10, 16'h0000, "t6_status");
        chk_start(n + 1, "t6_start");
        expq.delete();
        idle_lows(60, "t6_no_frame");

        // reset wins over a simultaneous store
        reset = 1'b1;
        wr(2'b00, 16'h0099);
        reset = 1'b0;
        rd(2'b00, 16'h0000, "t6_rst_wr_count");
        idle_lows(60, "t6_rst_wr_no_frame");

        chk("aborted_frames", aborted, 1);
        chk("expq_leftover", expq.size(), 0);
        chk("start_leftover", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
